// File: rtl/jtag_tap_core_if.sv
// JTAG pin-side and debug-side signal bundle for the TAP core.
// The host/bench drives the master side; the TAP core is the slave.
interface jtag_tap_core_if #(
    parameter int IR_WIDTH = 4,
    parameter int NUM_USER = 2
);
    logic                TMS;
    logic                TDI;
    logic                TDO;
    logic                tdo_en;
    logic [3:0]          state_out;
    logic [IR_WIDTH-1:0] ir_out;
    logic                tlr;
    logic                capture_dr;
    logic                shift_dr;
    logic                update_dr;
    logic [NUM_USER-1:0] user_sel;
    logic [NUM_USER-1:0] user_tdo;

    modport master (
        output TMS, TDI, user_tdo,
        input  TDO, tdo_en, state_out, ir_out, tlr,
               capture_dr, shift_dr, update_dr, user_sel
    );

    modport slave (
        input  TMS, TDI, user_tdo,
        output TDO, tdo_en, state_out, ir_out, tlr,
               capture_dr, shift_dr, update_dr, user_sel
    );
endinterface

// File: rtl/jtag_tap_core.sv
// IEEE 1149.1 TAP controller with IR, IDCODE and BYPASS registers,
// falling-edge TDO and decoded strobes for externally attached user DRs.
module jtag_tap_core #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP    = IR_WIDTH'(1),
    parameter int                  NUM_USER     = 2,
    parameter int                  USER_OP_BASE = 8
) (
    input  logic            TCK,
    input  logic            TRST,
    jtag_tap_core_if.slave  jtag
);

    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_e;

    tap_state_e          state, state_nxt;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_active;
    logic [31:0]         idcode_reg;
    logic                bypass_reg;
    logic [NUM_USER-1:0] user_sel;
    logic                sel_idcode;
    logic                sel_bypass;
    logic                dr_tdo;
    logic                tdo_q;
    logic                tdo_en_q;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state <= TLR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            TLR:    state_nxt = jtag.TMS ? TLR    : RTI;
            RTI:    state_nxt = jtag.TMS ? SEL_DR : RTI;
            SEL_DR: state_nxt = jtag.TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = jtag.TMS ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = jtag.TMS ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = jtag.TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_nxt = jtag.TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_nxt = jtag.TMS ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = jtag.TMS ? SEL_DR : RTI;
            SEL_IR: state_nxt = jtag.TMS ? TLR    : CAP_IR;
            CAP_IR: state_nxt = jtag.TMS ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = jtag.TMS ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = jtag.TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_nxt = jtag.TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_nxt = jtag.TMS ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = jtag.TMS ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // ---------------------------------------------------- instruction path
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr <= IR_WIDTH'(1);
        end else if (state == CAP_IR) begin
            ir_sr <= IR_WIDTH'(1);
        end else if (state == SH_IR) begin
            ir_sr <= {jtag.TDI, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // Falling-edge update keeps ir_active stable across the following posedge.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST)                ir_active <= IDCODE_OP;
        else if (state == TLR)    ir_active <= IDCODE_OP;
        else if (state == UPD_IR) ir_active <= ir_sr;
    end

    // ------------------------------------------------------------- decode
    for (genvar k = 0; k < NUM_USER; k++) begin : g_user_sel
        assign user_sel[k] = (ir_active == IR_WIDTH'(USER_OP_BASE + k));
    end

    // All-ones wins over a user opcode that happens to alias it.
    assign sel_idcode = (ir_active == IDCODE_OP);
    assign sel_bypass = !sel_idcode && ((&ir_active) || !(|user_sel));

    // ------------------------------------------------------ data registers
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            idcode_reg <= IDCODE_VAL;
        end else if (state == CAP_DR) begin
            idcode_reg <= IDCODE_VAL;
        end else if (state == SH_DR && sel_idcode) begin
            idcode_reg <= {jtag.TDI, idcode_reg[31:1]};
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_reg <= 1'b0;
        end else if (state == CAP_DR) begin
            bypass_reg <= 1'b0;
        end else if (state == SH_DR && sel_bypass) begin
            bypass_reg <= jtag.TDI;
        end
    end

    always_comb begin
        dr_tdo = bypass_reg;
        if (sel_idcode)      dr_tdo = idcode_reg[0];
        else if (!sel_bypass) dr_tdo = |(user_sel & jtag.user_tdo);
    end

    // ------------------------------------------------------------ TDO mux
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            unique case (state)
                SH_IR: begin
                    tdo_q    <= ir_sr[0];
                    tdo_en_q <= 1'b1;
                end
                SH_DR: begin
                    tdo_q    <= dr_tdo;
                    tdo_en_q <= 1'b1;
                end
                default: begin
                    tdo_q    <= 1'b0;
                    tdo_en_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    assign jtag.TDO        = tdo_q;
    assign jtag.tdo_en     = tdo_en_q;
    assign jtag.state_out  = state;
    assign jtag.ir_out     = ir_active;
    assign jtag.tlr        = (state == TLR);
    assign jtag.capture_dr = (state == CAP_DR);
    assign jtag.shift_dr   = (state == SH_DR);
    assign jtag.update_dr  = (state == UPD_DR);
    assign jtag.user_sel   = user_sel;

endmodule
